// File: rtl/riot_pkg.sv
// Shared constants for the RIOT-style port bank: register offsets within a
// port's four-register window and the derived register address width.
package riot_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_DDR  = 2'd1;
  localparam logic [1:0] REG_IEN  = 2'd2;
  localparam logic [1:0] REG_IFLG = 2'd3;

  // Four registers per port, so the address carries the port index above bit 1.
  function automatic int riot_addr_w(input int nports);
    return $clog2(nports * 4);
  endfunction

endpackage

// File: rtl/riot_port_bank_if.sv
// Register access bus between the chip decode (master) and the port bank (slave).
interface riot_port_bank_if #(
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 8
);
  // Access protocol: cs is a single-cycle strobe with no back-pressure; every
  // access completes in the cycle it is presented. we selects write (1) or
  // read (0). Read data appears on rdata the cycle after the strobe and holds
  // until the next read strobe.
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;

  modport master (output cs, output we, output addr, output wdata, input rdata);
  modport slave  (input cs, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/riot_port.sv
// One I/O port: output and direction registers, interrupt enable and flag
// registers, pad input synchroniser, edge detector and register read mux.
module riot_port
  import riot_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_RISE   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       reg_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] pin_oe,
  output logic [WIDTH-1:0] rd_val,
  output logic             irq_src
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] ddr_q, ddr_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] iflg_q, iflg_d;
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser shift and previous-sample tracking; prev follows the synced
  // value even in reset so no edge appears as reset is released.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    prev_d = synced;
  end

  // Sync chain and previous-sample register run freely, never cleared.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  // Edge detection and register next-state; a new edge wins over W1C clear.
  always_comb begin
    edge_hit = (EDGE_RISE != 0) ? (synced & ~prev_q) : (~synced & prev_q);
    clr      = (wr_en && reg_sel == REG_IFLG) ? wdata : '0;
    out_d    = (wr_en && reg_sel == REG_DATA) ? wdata : out_q;
    ddr_d    = (wr_en && reg_sel == REG_DDR)  ? wdata : ddr_q;
    ien_d    = (wr_en && reg_sel == REG_IEN)  ? wdata : ien_q;
    iflg_d   = (iflg_q & ~clr) | edge_hit;
  end

  // Architectural port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      ddr_q  <= '0;
      ien_q  <= '0;
      iflg_q <= '0;
    end else begin
      out_q  <= out_d;
      ddr_q  <= ddr_d;
      ien_q  <= ien_d;
      iflg_q <= iflg_d;
    end
  end

  // Read mux: DATA mixes driven bits (DDR=1) with synced pad bits (DDR=0).
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_DATA: rd_val = (out_q & ddr_q) | (synced & ~ddr_q);
      REG_DDR:  rd_val = ddr_q;
      REG_IEN:  rd_val = ien_q;
      REG_IFLG: rd_val = iflg_q;
      default:  rd_val = '0;
    endcase
  end

  assign pin_o   = out_q;
  assign pin_oe  = ddr_q;
  assign irq_src = |(iflg_q & ien_q);

endmodule

// File: rtl/riot_port_bank.sv
// Bank of NPORTS RIOT-style I/O ports: address decode, registered read data
// and the registered OR of all enabled interrupt flags.
module riot_port_bank
  import riot_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_RISE   = 1
) (
  input  logic                    phi2,
  input  logic                    rst,
  riot_port_bank_if.slave         bus,
  input  logic [NPORTS*WIDTH-1:0] pin_i,
  output logic [NPORTS*WIDTH-1:0] pin_o,
  output logic [NPORTS*WIDTH-1:0] pin_oe,
  output logic                    irq
);

  localparam int ADDR_W = riot_addr_w(NPORTS);

  logic [ADDR_W-1:0] port_idx;
  logic [1:0]        reg_sel;
  logic [NPORTS-1:0] port_sel;
  logic [NPORTS-1:0] irq_src;
  logic [WIDTH-1:0]  port_rd [NPORTS];
  logic [WIDTH-1:0]  rd_mux;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              irq_q, irq_d;

  assign port_idx = bus.addr >> 2;
  assign reg_sel  = bus.addr[1:0];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign port_sel[p] = (port_idx == ADDR_W'(p));

    riot_port #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_RISE   (EDGE_RISE)
    ) u_port (
      .clk     (phi2),
      .rst     (rst),
      .wr_en   (bus.cs & bus.we & port_sel[p]),
      .reg_sel (reg_sel),
      .wdata   (bus.wdata),
      .pin_i   (pin_i[p*WIDTH +: WIDTH]),
      .pin_o   (pin_o[p*WIDTH +: WIDTH]),
      .pin_oe  (pin_oe[p*WIDTH +: WIDTH]),
      .rd_val  (port_rd[p]),
      .irq_src (irq_src[p])
    );
  end

  // Select the addressed port's read value; unmapped ports read as zero.
  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_sel[p]) rd_mux = port_rd[p];
    end
    rdata_d = (bus.cs && !bus.we) ? rd_mux : rdata_q;
    irq_d   = |irq_src;
  end

  // Registered read data (held between reads) and interrupt request.
  always_ff @(posedge phi2) begin
    if (rst) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule
